// File: rtl/halftone_stream_converter.sv
// Streaming Floyd-Steinberg halftoner: one greyscale pixel in, one bit out per clock.
// Optional macro HT_ONES_COUNT_EN adds a ones_count output tallying accepted 1-bits.
module halftone_stream_converter #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 6,
  parameter int unsigned THRESH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_eol,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef HT_ONES_COUNT_EN
  ,output logic [$clog2(WIDTH*HEIGHT+1)-1:0] ones_count
`endif
);

  localparam int unsigned ERR_W = PIX_W + 2;
  localparam int unsigned SUM_W = ERR_W + 5;
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH*HEIGHT+1);
  localparam logic signed [SUM_W-1:0] ERR_HI = SUM_W'(2**(ERR_W-1) - 1);
  localparam logic signed [SUM_W-1:0] ERR_LO = ~ERR_HI;
  localparam logic signed [SUM_W-1:0] THR_S  = SUM_W'(THRESH);
  localparam logic signed [SUM_W-1:0] MAXV_S = SUM_W'(2**PIX_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t state, state_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic signed [ERR_W-1:0] lb [WIDTH];
  logic signed [ERR_W-1:0] e_left, e_ul;

  logic accept, out_fire, start_ok, first_row, first_col, last_col, last_pix, done_d;
  logic [COL_W-1:0] col_nx;
  logic signed [ERR_W-1:0] g_left, g_ul, g_up, g_ur, cpv, e_new;
  logic signed [SUM_W-1:0] t_left, t_ul, t_up, t_ur, s_sum, pix_ext, cpv_w, cpv_ext, e_w;
  logic pix_bit;

  function automatic logic signed [ERR_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > ERR_HI)      return ERR_HI[ERR_W-1:0];
    else if (v < ERR_LO) return ERR_LO[ERR_W-1:0];
    else                 return v[ERR_W-1:0];
  endfunction

  assign in_ready = (state == S_RUN) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign start_ok = (state == S_IDLE) & start;

  // Neighbour errors; out-of-frame neighbours are gated to zero so the line buffer never needs clearing
  always_comb begin
    first_row = (row == '0);
    first_col = (col == '0);
    last_col  = (col == COL_W'(WIDTH-1));
    last_pix  = last_col & (row == ROW_W'(HEIGHT-1));
    col_nx    = last_col ? col : col + COL_W'(1);
    g_left    = first_col ? '0 : e_left;
    g_ul      = (first_col | first_row) ? '0 : e_ul;
    g_up      = first_row ? '0 : lb[col];
    g_ur      = (last_col | first_row) ? '0 : lb[col_nx];
    t_left    = SUM_W'(g_left);
    t_ul      = SUM_W'(g_ul);
    t_up      = SUM_W'(g_up);
    t_ur      = SUM_W'(g_ur);
    s_sum     = (t_left <<< 3) - t_left + t_ul + (t_up <<< 2) + t_up + (t_ur <<< 1) + t_ur;
    pix_ext   = SUM_W'({1'b0, in_pixel});
    cpv_w     = pix_ext + (s_sum >>> 4);
    cpv       = sat(cpv_w);
    cpv_ext   = SUM_W'(cpv);
    pix_bit   = (cpv_ext >= THR_S);
    e_w       = pix_bit ? cpv_ext - MAXV_S : cpv_ext;
    e_new     = sat(e_w);
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_pix) state_d = S_FLUSH;
      S_FLUSH: if (out_fire && out_last) begin
                 state_d = S_IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      col       <= '0;
      row       <= '0;
      e_left    <= '0;
      e_ul      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != S_IDLE);
      done  <= done_d;
      if (start_ok) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col    <= last_col ? '0 : col + COL_W'(1);
        if (last_col) row <= last_pix ? '0 : row + ROW_W'(1);
        e_left <= e_new;
        e_ul   <= lb[col];
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_bit   <= pix_bit;
        out_eol   <= last_col;
        out_last  <= last_pix;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Previous-row errors, overwritten in place as the current row advances
  always_ff @(posedge clk) begin
    if (accept) lb[col] <= e_new;
  end

`ifdef HT_ONES_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ones_count <= '0;
    else if (start_ok)            ones_count <= '0;
    else if (out_fire && out_bit) ones_count <= ones_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_halftone_stream_converter.sv
// Randomised bench for halftone_stream_converter against an array-based error-diffusion model.
module tb_halftone_stream_converter;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [7:0] in_pixel;
  logic in_ready, out_valid, out_bit, out_eol, out_last, busy, done;
`ifdef HT_ONES_COUNT_EN
  logic [5:0] ones_count;
`endif

  halftone_stream_converter dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done)
`ifdef HT_ONES_COUNT_EN
    , .ones_count(ones_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pix [N];
  int exp_bit [N];
  int exp_ones;
  bit started = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int fdiv16(input int s);
    if (s >= 0) return s / 16;
    return -((-s + 15) / 16);
  endfunction

  function automatic int clampe(input int v);
    if (v > 511)  return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic void model();
    int e [H][W];
    int s, cpv, b;
    exp_ones = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        s = 0;
        if (c > 0) s += 7 * e[r][c-1];
        if (r > 0) begin
          if (c > 0) s += e[r-1][c-1];
          s += 5 * e[r-1][c];
          if (c < W-1) s += 3 * e[r-1][c+1];
        end
        cpv = clampe(pix[r*W+c] + fdiv16(s));
        b = (cpv >= 128) ? 1 : 0;
        e[r][c] = clampe(cpv - (b != 0 ? 255 : 0));
        exp_bit[r*W+c] = b;
        exp_ones += b;
      end
    end
  endfunction

  function automatic void fill(input int kind);
    for (int i = 0; i < N; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      case (kind)
        0: pix[i] = 0;
        1: pix[i] = (r < H/2 && c < W/2) ? 255 : 0;
        2: pix[i] = (r < H/2 && c < W/2) ? 0 : 255;
        3: pix[i] = 128;
        4: pix[i] = 31 + 32 * c;
        5: pix[i] = 255;
        default: pix[i] = int'($urandom_range(255));
      endcase
    end
  endfunction

  task automatic run_frame(input int kind, input int rdy_pct, input int vld_pct,
                           input bit mid_start, input bit chain_start, input int abort_at);
    int idx, oidx, cyc;
    bit last_hs, held, got_done;
    logic hb, he, hl;
    fill(kind);
    model();
    if (!started) begin
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    started = 1'b0;
    #1 check("busy_after_start", int'(busy), 1);
    idx = 0; oidx = 0; cyc = 0; last_hs = 0; held = 0; got_done = 0;
    hb = 0; he = 0; hl = 0;
    while (!got_done && cyc < 3000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (idx < N) && ($urandom_range(99) < vld_pct);
      in_pixel  = (idx < N) ? 8'(pix[idx]) : 8'($urandom);
      start     = mid_start && (idx == 10);
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_outs", int'({out_bit, out_eol, out_last}), 0);
        check("rst_busy_done", int'({busy, done, in_ready}), 0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #1 check("abort_no_done", int'({done, busy}), 0);
        end
        return;
      end
      #1;
      if (held) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_stable", int'({out_bit, out_eol, out_last}), int'({hb, he, hl}));
      end
      check("done", int'(done), int'(last_hs));
      if (done) begin
        got_done = 1;
`ifdef HT_ONES_COUNT_EN
        check("ones_count", int'(ones_count), exp_ones);
`endif
      end
      last_hs = 0;
      if (out_valid && out_ready) begin
        if (oidx < N) begin
          check("out_bit", int'(out_bit), exp_bit[oidx]);
          check("out_eol", int'(out_eol), (oidx % W == W-1) ? 1 : 0);
          check("out_last", int'(out_last), (oidx == N-1) ? 1 : 0);
          last_hs = (oidx == N-1);
        end else begin
          check("extra_output", oidx, N-1);
        end
        oidx++;
      end
      held = out_valid && !out_ready;
      hb = out_bit; he = out_eol; hl = out_last;
      if (in_valid && in_ready) idx++;
      if (got_done && chain_start) begin
        start = 1'b1;
        started = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got_done) check("timeout", 0, 1);
    check("out_count", oidx, N);
    start = 1'b0; in_valid = 1'b0;
    #1 check("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
    #2;
    check("reset_outs", int'({out_valid, out_bit, out_eol, out_last}), 0);
    check("reset_ctrl", int'({in_ready, busy, done}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 100, 100, 0, 0, -1);
    run_frame(1, 100, 100, 0, 0, -1);
    run_frame(2, 100, 100, 0, 0, -1);
    run_frame(3, 100, 100, 0, 0, -1);
    run_frame(4, 100, 100, 0, 0, -1);
    run_frame(4, 50, 70, 0, 0, -1);
    run_frame(6, 60, 60, 1, 1, -1);
    run_frame(3, 70, 80, 0, 0, -1);
    run_frame(6, 100, 100, 0, 0, 20);
    run_frame(5, 100, 100, 0, 0, -1);
    run_frame(6, 30, 50, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
